// File: rtl/pll_reset_sequencer.sv
// PLL lock qualifier and video/core reset sequencer with CPU clock-enable.
// Optional lock-loss event counter: define LOCK_LOSS_CNT_EN.
module pll_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CORE_DELAY_CYCLES  = 16,
  parameter int CE_DIV             = 4
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       reset_video,
  output logic       reset_core,
  output logic       ce_cpu,
`ifdef LOCK_LOSS_CNT_EN
  output logic [7:0] lock_loss_cnt,
`endif
  output logic [1:0] seq_state
);

  localparam int MAX_AB =
    (LOCK_STABLE_CYCLES > CORE_DELAY_CYCLES) ?
    LOCK_STABLE_CYCLES : CORE_DELAY_CYCLES;
  localparam int MAX_P =
    (MAX_AB > CE_DIV) ? MAX_AB : CE_DIV;
  localparam int CW = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] STABLE_LAST =
    CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CORE_LAST =
    CW'(CORE_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST =
    CW'(CE_DIV - 1);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_STABLE = 2'd1,
    S_VIDEO  = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic          locked_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div_q, div_d;
  logic          rv_d, rc_d, ce_d;
  logic          lost;

  assign locked_s  = sync_q[1];
  assign seq_state = state_q;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sync_q      <= 2'b00;
      state_q     <= S_WAIT;
      cnt_q       <= '0;
      div_q       <= '0;
      reset_video <= 1'b1;
      reset_core  <= 1'b1;
      ce_cpu      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], pll_locked};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      reset_video <= rv_d;
      reset_core  <= rc_d;
      ce_cpu      <= ce_d;
    end
  end

  // Lock loss is tested before terminal count so it always wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    lost    = 1'b0;
    unique case (state_q)
      S_WAIT: begin
        if (locked_s) state_d = S_STABLE;
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_d = S_WAIT;
          lost    = 1'b1;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_VIDEO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_VIDEO: begin
        if (!locked_s) begin
          state_d = S_WAIT;
          lost    = 1'b1;
        end else if (cnt_q == CORE_LAST) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_d = S_WAIT;
          lost    = 1'b1;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  // Divider only runs while staying in RUN, so it sits at 0 in reset.
  always_comb begin
    rv_d  = (state_d == S_WAIT) || (state_d == S_STABLE);
    rc_d  = (state_d != S_RUN);
    div_d = '0;
    ce_d  = 1'b0;
    if (state_q == S_RUN && state_d == S_RUN) begin
      ce_d  = (div_q == DIV_LAST);
      div_d = (div_q == DIV_LAST) ? '0 : div_q + CW'(1);
    end
  end

`ifdef LOCK_LOSS_CNT_EN
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      lock_loss_cnt <= 8'd0;
    end else if (lost && lock_loss_cnt != 8'hff) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomised bench for pll_reset_sequencer against an elapsed-time model.
// Two DUTs share stimulus: CE_DIV=3 and CE_DIV=1.
module tb_pll_reset_sequencer;

  localparam int N   = 4;
  localparam int D   = 2;
  localparam int DIV = 3;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       rv, rc, ce;
  logic       rv1, rc1, ce1;
  logic [1:0] st, st1;
`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] llc, llc1;
`endif

  int n_vec = 0;
  int n_bad = 0;

  // Model: sync pipe, active flag, edges since STABLE entry, losses.
  bit m_s0, m_s1;
  bit m_act;
  int m_e;
  int m_loss;

  always #5 clk_sys = ~clk_sys;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(N),
    .CORE_DELAY_CYCLES(D),
    .CE_DIV(DIV)
  ) dut (
    .clk_sys(clk_sys),
    .rst(rst),
    .pll_locked(pll_locked),
    .reset_video(rv),
    .reset_core(rc),
    .ce_cpu(ce),
`ifdef LOCK_LOSS_CNT_EN
    .lock_loss_cnt(llc),
`endif
    .seq_state(st)
  );

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(N),
    .CORE_DELAY_CYCLES(D),
    .CE_DIV(1)
  ) dut1 (
    .clk_sys(clk_sys),
    .rst(rst),
    .pll_locked(pll_locked),
    .reset_video(rv1),
    .reset_core(rc1),
    .ce_cpu(ce1),
`ifdef LOCK_LOSS_CNT_EN
    .lock_loss_cnt(llc1),
`endif
    .seq_state(st1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0d exp %0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_state();
    if (!m_act) return 0;
    if (m_e < N) return 1;
    if (m_e < N + D) return 2;
    return 3;
  endfunction

  function automatic int m_ce(input int div);
    int k;
    if (!m_act) return 0;
    k = m_e - N - D;
    if (k < 1) return 0;
    return (k % div == 0) ? 1 : 0;
  endfunction

  task automatic model_edge();
    bit ls;
    if (rst) begin
      m_s0  = 0;
      m_s1  = 0;
      m_act = 0;
      m_e   = 0;
    end else begin
      ls   = m_s1;
      m_s1 = m_s0;
      m_s0 = pll_locked;
      if (!m_act) begin
        if (ls) begin
          m_act = 1;
          m_e   = 0;
        end
      end else if (!ls) begin
        m_act = 0;
        if (m_loss < 255) m_loss++;
      end else begin
        m_e++;
      end
    end
  endtask

  task automatic step();
    int ms;
    @(posedge clk_sys);
    model_edge();
    #1;
    ms = m_state();
    chk("seq_state", int'(st), ms);
    chk("reset_video", int'(rv), (m_act && m_e >= N) ? 0 : 1);
    chk("reset_core", int'(rc), (m_act && m_e >= N + D) ? 0 : 1);
    chk("ce_cpu", int'(ce), m_ce(DIV));
    chk("ce_cpu_div1", int'(ce1), m_ce(1));
    chk("seq_state_div1", int'(st1), ms);
`ifdef LOCK_LOSS_CNT_EN
    chk("lock_loss_cnt", int'(llc), m_loss);
`endif
  endtask

  initial begin
    m_s0 = 0; m_s1 = 0; m_act = 0; m_e = 0; m_loss = 0;
    rst = 1'b1;
    pll_locked = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    pll_locked = 1'b1;
    repeat (20) step();
    pll_locked = 1'b0;
    repeat (5) step();

    pll_locked = 1'b1;
    repeat (4) step();
    pll_locked = 1'b0;
    repeat (5) step();
    pll_locked = 1'b1;
    repeat (10) step();

    pll_locked = 1'b0;
    repeat (4) step();
    pll_locked = 1'b1;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        rst = 1'b0;
      end else begin
        pll_locked = ($urandom_range(0, 2) != 0);
        repeat ($urandom_range(1, 20)) step();
      end
    end

    pll_locked = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      repeat (6) step();
      pll_locked = 1'b0;
      repeat (3) step();
    end
`ifdef LOCK_LOSS_CNT_EN
    chk("lock_loss_sat", int'(llc), 255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
